// File: rtl/mux_arb_nto1_rr_pick.sv
// Rotating priority encoder: first set req bit at or after base, wrapping modulo N.
// Purely combinational; no state, no handshake.
module rr_pick #(
  parameter  int N     = 8,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] base,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  always_comb begin
    int b;
    int j;
    found = 1'b0;
    idx   = '0;
    // Reduce base first so an out-of-range pointer still scans every requester once.
    b = int'(base) % N;
    for (int k = 0; k < N; k++) begin
      j = b + k;
      if (j >= N) j = j - N;
      if (!found && req[SEL_W'(j)]) begin
        found = 1'b1;
        idx   = SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// Registered N:1 selector, direct or round-robin grant; one cycle latency.
// A held word that is not taken stalls all inputs (in_ready all zero) until out_ready.
module mux_arb_nto1 #(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  localparam int PAD = 1 << SEL_W;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;
  logic [SEL_W-1:0] r_rr_ptr;

  logic [WIDTH-1:0]    w_ch [CHANNELS];
  logic [PAD-1:0]      w_valid_pad;
  logic                w_rr_found;
  logic [SEL_W-1:0]    w_rr_idx;
  logic                w_gnt_vld;
  logic [SEL_W-1:0]    w_gnt_idx;
  logic                w_slot_free;
  logic                w_accept;
  logic [SEL_W-1:0]    w_rr_next;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign w_ch[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Zero padding up to 2**SEL_W makes any out-of-range sel read a 0 request.
  assign w_valid_pad = PAD'(in_valid);

  rr_pick #(.N(CHANNELS)) u_rr_pick (
    .req   (in_valid),
    .base  (r_rr_ptr),
    .found (w_rr_found),
    .idx   (w_rr_idx)
  );

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (mode) begin
      w_gnt_vld = w_rr_found;
      w_gnt_idx = w_rr_idx;
    end else begin
      w_gnt_vld = w_valid_pad[sel];
      w_gnt_idx = sel;
    end
  end

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_accept    = w_gnt_vld && w_slot_free && !rst;
  assign in_ready    = w_accept ? (CHANNELS'(1) << w_gnt_idx) : '0;
  assign w_rr_next   = (w_gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_ch[w_gnt_idx];
      r_out_sel   <= w_gnt_idx;
      if (mode) r_rr_ptr <= w_rr_next;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Directed bench for mux_arb_nto1 at 8 and 5 channels; expected words queued at grant, popped at output.
module tb_mux_arb_nto1;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          n_assert = 0;
  int          n_fail   = 0;

  // 8-channel instance
  logic        mode, out_ready;
  logic [2:0]  sel;
  logic [7:0]  in_valid, in_ready;
  logic [127:0] in_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  out_sel;
  logic [15:0] ch_dat [8];

  // 5-channel instance
  logic        mode5, out_ready5;
  logic [2:0]  sel5;
  logic [4:0]  in_valid5, in_ready5;
  logic [79:0] in_data5;
  logic        out_valid5;
  logic [15:0] out_data5;
  logic [2:0]  out_sel5;

  exp_t        sb_q[$];
  exp_t        sb_q5[$];
  exp_t        e;
  logic        exp_valid, exp_valid5;
  logic [15:0] exp_data, exp_data5;
  logic [2:0]  exp_sel, exp_sel5;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) in_data[i*16 +: 16] = ch_dat[i];
    for (int i = 0; i < 5; i++) in_data5[i*16 +: 16] = 16'h5000 + 16'(i);
  end

  mux_arb_nto1 #(.WIDTH(16), .CHANNELS(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
  );

  mux_arb_nto1 #(.WIDTH(16), .CHANNELS(5)) dut5 (
    .clk(clk), .rst(rst), .mode(mode5), .sel(sel5), .in_valid(in_valid5),
    .in_data(in_data5), .in_ready(in_ready5), .out_valid(out_valid5),
    .out_data(out_data5), .out_sel(out_sel5), .out_ready(out_ready5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] r = 3'd0;
    for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction

  // One cycle on the 8-channel DUT: inputs already driven, exp_rdy is the required grant.
  task automatic step(input string tag, input logic [7:0] exp_rdy);
    exp_t x;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    if (exp_rdy != 8'h00) begin
      x.s = oh2idx(exp_rdy);
      x.d = ch_dat[x.s];
      sb_q.push_back(x);
    end
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      exp_valid = 1'b1;
      exp_data  = e.d;
      exp_sel   = e.s;
    end else if (out_ready) begin
      exp_valid = 1'b0;
    end
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    chk({tag, ".out_data"},  32'(out_data),  32'(exp_data));
    chk({tag, ".out_sel"},   32'(out_sel),   32'(exp_sel));
    @(negedge clk);
  endtask

  task automatic step5(input string tag, input logic [4:0] exp_rdy);
    exp_t x;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready5), 32'(exp_rdy));
    if (exp_rdy != 5'h00) begin
      x.s = oh2idx(8'(exp_rdy));
      x.d = 16'h5000 + 16'(x.s);
      sb_q5.push_back(x);
    end
    @(posedge clk);
    #1;
    if (sb_q5.size() != 0) begin
      e = sb_q5.pop_front();
      exp_valid5 = 1'b1;
      exp_data5  = e.d;
      exp_sel5   = e.s;
    end else if (out_ready5) begin
      exp_valid5 = 1'b0;
    end
    chk({tag, ".out_valid"}, 32'(out_valid5), 32'(exp_valid5));
    chk({tag, ".out_data"},  32'(out_data5),  32'(exp_data5));
    chk({tag, ".out_sel"},   32'(out_sel5),   32'(exp_sel5));
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ch_dat[i] = 16'hA000 + 16'(i);
    ch_dat[3] = 16'hBEEF;
    rst = 1'b1; mode = 1'b0; sel = 3'd3; in_valid = 8'h08; out_ready = 1'b1;
    mode5 = 1'b0; sel5 = 3'd6; in_valid5 = 5'h1F; out_ready5 = 1'b1;
    exp_valid = 1'b0; exp_data = 16'h0; exp_sel = 3'd0;
    exp_valid5 = 1'b0; exp_data5 = 16'h0; exp_sel5 = 3'd0;

    // Reset: outputs cleared, in_ready held low despite a live request.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'h0);
    chk("rst.out_valid", 32'(out_valid), 32'h0);
    chk("rst.out_data", 32'(out_data), 32'h0);
    chk("rst.out_sel", 32'(out_sel), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Direct select, then reset mid-stream drops the held word.
    step("direct0", 8'h08);
    step("direct1", 8'h08);
    rst = 1'b1;
    #1;
    chk("midrst.in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'h0);
    chk("midrst.out_data", 32'(out_data), 32'h0);
    chk("midrst.out_sel", 32'(out_sel), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_valid = 1'b0; exp_data = 16'h0; exp_sel = 3'd0;
    exp_valid5 = 1'b0; exp_data5 = 16'h0; exp_sel5 = 3'd0;

    // Direct miss: sel points at an idle channel, ch3 must not be taken.
    step("dload", 8'h08);
    sel = 3'd5;
    step("dmiss0", 8'h00);
    step("dmiss1", 8'h00);

    // Round-robin, all requesting: 0..7 then 0, one per cycle.
    mode = 1'b1; in_valid = 8'hFF;
    for (int k = 0; k < 9; k++) step($sformatf("rr%0d", k), 8'(1 << (k % 8)));
    step("rr_to2", 8'h02);

    // Skip and wrap with rr_ptr=2.
    in_valid = 8'b1000_0010;
    step("wrap7a", 8'h80);
    step("wrap1", 8'h02);
    step("wrap7b", 8'h80);

    // Backpressure on a held 1234, then a zero-bubble reload.
    mode = 1'b0; sel = 3'd2; in_valid = 8'h04; ch_dat[2] = 16'h1234;
    step("bp_load", 8'h04);
    out_ready = 1'b0; ch_dat[2] = 16'h5678;
    for (int k = 0; k < 4; k++) step($sformatf("bp_stall%0d", k), 8'h00);
    out_ready = 1'b1;
    step("bp_release", 8'h04);
    in_valid = 8'h00;
    step("bp_drain", 8'h00);

    // rr_ptr sat at 0 after the wrap and direct mode left it alone.
    mode = 1'b1; in_valid = 8'hFF;
    step("rr_keep", 8'h01);

    // Five channels: out-of-range sel never grants; rr wraps from 4 to 0.
    step5("c5_sel6", 5'h00);
    mode5 = 1'b1; in_valid5 = 5'b01000;
    step5("c5_to4", 5'b01000);
    in_valid5 = 5'b10001;
    step5("c5_g4", 5'b10000);
    step5("c5_g0", 5'b00001);
    step5("c5_g4b", 5'b10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_arb_nto1.md
Name: mux_arb_nto1

Overview:
- Parametrised, registered N-to-1 data selector; successor to the fixed 16-bit 8:1 combinational mux.
- Adds a per-channel valid/ready handshake and two grant modes:
  - direct: the select port picks the channel;
  - round-robin: rotating fair arbitration among requesting channels.
- Sits between multiple producers (register-file read ports, ALU/memory result paths) and one consumer stage in the RISC datapath. Registered output gives one cycle of latency.

Parameters:
- WIDTH, 16, data width per channel.
- CHANNELS, 8, number of input channels (>=2; need not be a power of two).
- SEL_W, derived localparam = clog2(CHANNELS), width of select/index fields.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = direct select, 1 = round-robin.
- sel  input  SEL_W  channel index used in direct mode.
- in_valid  input  CHANNELS  per-channel request.
- in_data  input  CHANNELS*WIDTH  packed inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  CHANNELS  one-hot accept; combinational.
- out_valid  output  1  output register holds data.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  index of the channel that produced out_data.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_sel=0, rr_ptr=0. in_ready is all-zero while rst=1. Reset mid-transfer discards the held word.
- slot_free = !out_valid || out_ready.
- Grant g, computed combinationally:
  - Direct mode: g=sel if sel<CHANNELS and in_valid[sel], else no grant. Out-of-range sel never grants.
  - Round-robin mode: g is the first i with in_valid[i], scanning rr_ptr, rr_ptr+1, … and wrapping modulo CHANNELS. No grant if in_valid is all zero.
- in_ready[g]=slot_free when a grant exists; all other in_ready bits are 0. in_ready is never multi-hot.
- Accept (in_valid[g] && in_ready[g]) at a clk edge:
  - out_data <= channel g data, out_sel <= g, out_valid <= 1.
  - In round-robin mode only: rr_ptr <= (g+1) mod CHANNELS. Wrap from CHANNELS-1 goes to 0.
- No accept and out_ready=1: out_valid <= 0; out_data and out_sel hold their last values.
- Stall (out_valid=1, out_ready=0): out_data, out_sel and out_valid hold stable, and in_ready is all zero.
- Simultaneous out_ready=1 and new accept in the same cycle: the new word replaces the old one, out_valid stays 1. Full throughput is 1 word/cycle.
- Latency: an input accepted at edge k is visible on out_data after edge k.
- Mode and sel are sampled every cycle. A change affects the next grant only, never the held word. rr_ptr is preserved across mode switches and does not advance in direct mode.
- No combinational path from in_data to out_data. The only combinational paths are in_valid/sel/mode/out_ready -> in_ready.

Decomposition:
- No shared package needed. The clog2 helper goes in the project's common constants include if one exists, otherwise it is local.
- Natural sub-module: rr_pick.
  - Parameter N.
  - Inputs: req[N], base[SEL_W].
  - Outputs: found, idx.
  - Purely combinational rotating priority encoder, reused by later arbiters.

Test Plan:
- Reset/direct basic: CHANNELS=8, WIDTH=16, mode=0, sel=3, in_valid=8'h08, ch3=16'hBEEF, out_ready=1. Required: in_ready=8'h08; next cycle out_valid=1, out_data=BEEF, out_sel=3. Assert rst mid-stream: next cycle out_valid=0, out_data=0.
- Direct miss: sel=5, in_valid=8'h08. Required: in_ready=0, out_valid drops to 0 after one cycle, and ch3 is never accepted.
- Round-robin fairness: mode=1, in_valid=8'hFF held, out_ready=1. Required: out_sel sequence 0,1,2,…,7,0 on consecutive cycles with no bubbles.
- Round-robin skip and wrap: in_valid=8'b1000_0010, rr_ptr=2. Required: grant 7, then rr_ptr=0, then grant 1, then grant 7.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1, data=16'h1234. Required: out_data stays 1234, in_ready=0 throughout. On out_ready=1 with a pending request, a new word loads the same cycle with no bubble.
- Non-power-of-two: CHANNELS=5, mode=0, sel=6. Required: no grant. Mode=1 with in_valid=5'b10001 and rr_ptr=4: grants 4, then 0.
